// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and helpers for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MFHI  = 3'b100,
    MDU_MFLO  = 3'b101,
    MDU_MTHI  = 3'b110,
    MDU_MTLO  = 3'b111
  } MduOp;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } MduState;

  // valid=0 means HI/LO must be left untouched (divide by zero)
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
  } mdu_res_t;

  function automatic logic is_long_op(input MduOp f_op);
    return (f_op == MDU_MULT) || (f_op == MDU_MULTU) ||
           (f_op == MDU_DIV)  || (f_op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input MduOp f_op);
    return (f_op == MDU_DIV) || (f_op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enable,
  input  logic [2:0]  op,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  MduState          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  MduOp             op_q, op_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             busy_q, busy_d;
  mdu_res_t         arith;
  MduOp             op_in;

  // Signed division works on magnitudes so 0x80000000 / -1 wraps back to
  // 0x80000000 without a special case.
  function automatic mdu_res_t mdu_arith(input MduOp f_op, input logic [31:0] a,
                                         input logic [31:0] b);
    mdu_res_t    res;
    logic [63:0] prod;
    logic [31:0] ua, ub, uq, ur;
    logic        sgn;
    res  = '0;
    prod = '0;
    uq   = '0;
    ur   = '0;
    sgn  = (f_op == MDU_DIV);
    ua   = (sgn && a[31]) ? -a : a;
    ub   = (sgn && b[31]) ? -b : b;
    case (f_op)
      MDU_MULT: begin
        prod      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.hi    = prod[63:32];
        res.lo    = prod[31:0];
        res.valid = 1'b1;
      end
      MDU_MULTU: begin
        prod      = {32'd0, a} * {32'd0, b};
        res.hi    = prod[63:32];
        res.lo    = prod[31:0];
        res.valid = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        if (ub != 32'd0) begin
          uq        = ua / ub;
          ur        = ua % ub;
          res.lo    = (sgn && (a[31] ^ b[31])) ? -uq : uq;
          res.hi    = (sgn && a[31]) ? -ur : ur;
          res.valid = 1'b1;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  assign op_in = MduOp'(op);
  assign arith = mdu_arith(op_q, rs_q, rt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (start && is_long_op(op_in)) begin
            op_d    = op_in;
            rs_d    = rsData;
            rt_d    = rtData;
            cnt_d   = is_div_op(op_in) ? DIV_LOAD : MULT_LOAD;
            state_d = RUN;
          end else if (op_in == MDU_MTHI) begin
            hi_d = rsData;
          end else if (op_in == MDU_MTLO) begin
            lo_d = rsData;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (arith.valid) begin
            hi_d = arith.hi;
            lo_d = arith.lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULT;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    result = 32'd0;
    if (op_in == MDU_MFHI) result = hi_q;
    else if (op_in == MDU_MFLO) result = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu against a timeline model
module tb_mdu;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset, start, enable;
  logic [2:0]  op;
  logic [31:0] rsData, rtData;
  logic        busy;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .op(op),
    .rsData(rsData), .rtData(rtData), .busy(busy), .result(result),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic and an absolute cycle timeline
  int          cyc = 0;
  int          m_done = 0;
  logic        m_run = 1'b0;
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [2:0]  m_op = 0;

  function automatic logic [63:0] model_exec(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] oh,
                                              input logic [31:0] ol);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd2: begin
        if (b == 0) return {oh, ol};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {oh, ol};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi  <= 0;
      m_lo  <= 0;
      m_run <= 1'b0;
    end else if (m_run) begin
      if (cyc == m_done) begin
        m_run <= 1'b0;
        {m_hi, m_lo} <= model_exec(m_op, m_a, m_b, m_hi, m_lo);
      end
    end else if (enable) begin
      if (start && op <= 3'd3) begin
        m_run  <= 1'b1;
        m_done <= cyc + ((op <= 3'd1) ? NM : ND);
        m_op   <= op;
        m_a    <= rsData;
        m_b    <= rtData;
      end else if (op == 3'd6) begin
        m_hi <= rsData;
      end else if (op == 3'd7) begin
        m_lo <= rsData;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_run});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("result", result, (op == 3'd4) ? m_hi : (op == 3'd5) ? m_lo : 32'd0);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = (o <= 3'd3);
    enable = 1'b1;
    op     = o;
    rsData = a;
    rtData = b;
    @(posedge clk); #1;
    start  = 1'b0;
    enable = 1'b0;
    op     = 3'd0;
    rsData = 32'hA5A5_A5A5;
    rtData = 32'h5A5A_5A5A;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 100) check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; enable = 1'b0; op = 3'd0; rsData = 0; rtData = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3); wait_idle(n);
    check("mult_lat", n, NM);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3); wait_idle(n);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_idle(n);
    check("div_lat", n, ND);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd2); wait_idle(n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(n);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    issue(3'd6, 32'h11, 32'd0);
    issue(3'd7, 32'h22, 32'd0);
    issue(3'd2, 32'd5, 32'd0); wait_idle(n);
    check("div0_lat", n, ND);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    issue(3'd6, 32'hDEAD_BEEF, 32'd0);
    op = 3'd4; enable = 1'b1; #1;
    check("mfhi", result, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    enable = 1'b0;

    issue(3'd0, 32'd4, 32'd5);
    @(posedge clk); #1;
    op = 3'd5; enable = 1'b1; #1;
    check("mflo_run", result, 32'h22);
    wait_idle(n);
    check("mflo_after", result, 32'd20);
    enable = 1'b0; op = 3'd0;

    issue(3'd0, 32'd6, 32'd7);
    start = 1'b1; enable = 1'b1; op = 3'd0; rsData = 32'd100; rtData = 32'd100;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd6; rsData = 32'h55;
    @(posedge clk); #1;
    enable = 1'b0; op = 3'd0;
    wait_idle(n);
    check("restart_lo", lo, 32'd42);
    check("restart_hi", hi, 32'd0);

    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_hi_late", hi, 32'd0);
    check("abort_lo_late", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage: executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, owns the architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. It is driven by the `mduOp`, `mduStart` and `mduEnable` fields of `EXSignal` together with forwarded rs/rt data. Its `result` feeds the EX result mux when `exResult`=1. Its `busy` feeds the hazard unit's stall logic.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).

- `clk`  in  1  single clock; everything on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  `EXSignal.mduStart`; one-cycle pulse per mult/div instruction.
- `enable`  in  1  `EXSignal.mduEnable`; an MDU instruction occupies EX this cycle.
- `op`  in  3  `EXSignal.mduOp`.
- `rsData`  in  32  forwarded rs operand.
- `rtData`  in  32  forwarded rt operand.
- `busy`  out  1  registered; operation in flight.
- `result`  out  32  combinational HI (MFHI) or LO (MFLO); 0 for other ops.
- `hi`, `lo`  out  32 each  current HI/LO, for debug/trace.

## Operation
- `op` encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- States: IDLE, RUN. Counter `cnt` (width clog2(max latency)+1).
- IDLE, `start`=1, `op`∈{000..011}:
  - latch op and both operands;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- `start` with any other op, or with `enable`=0, is ignored.
- RUN: decrement `cnt` each cycle. On the edge where `cnt` goes 1→0, commit HI/LO and return to IDLE.
- MULT: signed 32×32 → 64. HI = product[63:32], LO = product[31:0]. MULTU: same, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with the dividend's sign. DIVU: unsigned.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divisor 0: HI and LO are left unchanged; busy still lasts DIV_CYCLES.
- Result is computed from the latched operands. Upstream changes to rsData/rtData after `start` have no effect.
- MTHI/MTLO: when `enable`=1 and state is IDLE, write rsData into HI/LO at the edge.
- In RUN, `start`, MTHI and MTLO are ignored. The hazard unit prevents them by stalling on `busy | start` while an MDU instruction sits in ID.
- MFHI/MFLO read the registered HI/LO. A read during RUN returns the pre-operation value; the hazard unit stalls such reads.

## Timing
- Reset: `busy`=0, HI=LO=0, state IDLE, `cnt`=0.
- Reset during RUN aborts the operation; HI/LO are cleared and no commit occurs.
- `start` sampled high at edge of cycle T:
  - `busy`=1 for cycles T+1..T+N (N = latency);
  - HI/LO updated at the end of T+N, visible in T+N+1, when `busy`=0;
  - the earliest next accepted `start` is in cycle T+N+1.
- `result` is combinational from `op`, HI and LO. It has zero latency and reflects HI/LO as registered this cycle.
- MTHI/MTLO take effect at the end of the same cycle; the new value is visible the next cycle.
- Commit in cycle T+N and an MT in T+N cannot coexist, because the MT is stalled while `busy`=1.

## Structure
- Add to `defs`:
  - `MduOp` enum (3 bits, encoding above);
  - `MduState` enum {IDLE, RUN}.
- Change `EXSignal.mduOp` to type `MduOp`.
- No sub-module. The 64-bit product and the quotient/remainder come from a combinational `mdu_arith` function block on the latched operands, inside `mdu`.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3 → busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=−7 (0xFFFFFFF9), rt=2 → busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIV x/0 with prior HI=0x11, LO=0x22 → HI/LO remain 0x11/0x22 after 10 busy cycles.
- MTHI 0xDEADBEEF, then MFHI next cycle → `result`=0xDEADBEEF. MFLO issued during RUN of MULT 4×5 → old LO; MFLO after busy falls → 20.
- Change rsData/rtData and pulse `start` again mid-RUN → ignored; the committed result matches the original operands.
- Assert `reset` in cycle 3 of a DIV → next cycle `busy`=0, HI=LO=0; no later commit.
